// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges the single-cycle ALU result and a FIFO of LSU results
// onto the register-file write port, with a bounded-starvation guarantee for the FIFO.

module wb_arb_pend_slot (
  input  logic       vld_i,
  input  logic [4:0] rd_i,
  input  logic [4:0] q1_i,
  input  logic [4:0] q2_i,
  output logic       hit1_o,
  output logic       hit2_o
);
  assign hit1_o = vld_i && (rd_i == q1_i);
  assign hit2_o = vld_i && (rd_i == q2_i);
endmodule

module wb_arbiter #(
  parameter int DEPTH      = 4,
  parameter int STARVE_MAX = 3
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        alu_valid,
  output logic        alu_ready,
  input  logic [4:0]  alu_rd,
  input  logic [31:0] alu_data,
  input  logic        lsu_valid,
  output logic        lsu_ready,
  input  logic [4:0]  lsu_rd,
  input  logic [31:0] lsu_data,
  output logic        reg_wr,
  output logic [4:0]  waddr,
  output logic [31:0] wdata,
  input  logic [4:0]  qaddr1,
  input  logic [4:0]  qaddr2,
  output logic        pend1,
  output logic        pend2
);
  localparam int AW = $clog2(DEPTH);
  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [AW:0]   FULL_CNT   = (AW + 1)'(DEPTH);
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic [SW-1:0] starve_q, starve_d;
  logic [4:0]    rd_mem_q   [DEPTH];
  logic [31:0]   data_mem_q [DEPTH];
  logic          reg_wr_q, reg_wr_d;
  logic [4:0]    waddr_q, waddr_d;
  logic [31:0]   wdata_q, wdata_d;

  logic full, alu_write, push, pop;

  always_comb begin
    full      = (count_q == FULL_CNT);
    lsu_ready = !full;
    // One forced bubble for the ALU once a full FIFO has been blocked STARVE_MAX times.
    alu_ready = !(full && (starve_q == STARVE_LIM));
    alu_write = alu_valid && alu_ready && (alu_rd != 5'd0);
    push      = lsu_valid && lsu_ready && (lsu_rd != 5'd0);
    pop       = !alu_write && (count_q != '0);
  end

  always_comb begin
    reg_wr_d = 1'b0;
    waddr_d  = waddr_q;
    wdata_d  = wdata_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    starve_d = '0;
    if (alu_write) begin
      reg_wr_d = 1'b1;
      waddr_d  = alu_rd;
      wdata_d  = alu_data;
    end else if (pop) begin
      reg_wr_d = 1'b1;
      waddr_d  = rd_mem_q[rd_ptr_q];
      wdata_d  = data_mem_q[rd_ptr_q];
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    // A full FIFO is only ever kept from popping by an ALU write.
    if (full && alu_write)
      starve_d = (starve_q == STARVE_LIM) ? starve_q : starve_q + 1'b1;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      starve_q <= '0;
      reg_wr_q <= 1'b0;
      waddr_q  <= '0;
      wdata_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      starve_q <= starve_d;
      reg_wr_q <= reg_wr_d;
      waddr_q  <= waddr_d;
      wdata_q  <= wdata_d;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        rd_mem_q[i]   <= '0;
        data_mem_q[i] <= '0;
      end
    end else if (push) begin
      rd_mem_q[wr_ptr_q]   <= lsu_rd;
      data_mem_q[wr_ptr_q] <= lsu_data;
    end
  end

  assign reg_wr = reg_wr_q;
  assign waddr  = waddr_q;
  assign wdata  = wdata_q;

  // An entry is live when its distance from the read pointer is below the count.
  logic [DEPTH-1:0] hit1, hit2;
  genvar g;
  generate
    for (g = 0; g < DEPTH; g++) begin : g_slot
      logic [AW-1:0] ofs;
      logic          vld;
      assign ofs = AW'(g) - rd_ptr_q;
      assign vld = ({1'b0, ofs} < count_q);
      wb_arb_pend_slot u_slot (
        .vld_i  (vld),
        .rd_i   (rd_mem_q[g]),
        .q1_i   (qaddr1),
        .q2_i   (qaddr2),
        .hit1_o (hit1[g]),
        .hit2_o (hit2[g])
      );
    end
  endgenerate

  assign pend1 = (qaddr1 != 5'd0) && ((|hit1) || (reg_wr_q && (waddr_q == qaddr1)));
  assign pend2 = (qaddr2 != 5'd0) && ((|hit2) || (reg_wr_q && (waddr_q == qaddr2)));

endmodule
